// File: rtl/multicycle_control32_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcode/funct constants,
// FSM state encoding (visible on the debug port), PC source encodings and the
// decoded instruction-class record produced by multicycle_control32_decode.
package multicycle_control32_pkg;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [2:0] OpIPrefix = 3'b001;

  localparam logic [5:0] FunctJr   = 6'b001000;
  localparam logic [5:0] FunctSll  = 6'b000000;
  localparam logic [5:0] FunctSrl  = 6'b000010;
  localparam logic [5:0] FunctSra  = 6'b000011;
  localparam logic [5:0] FunctSllv = 6'b000100;
  localparam logic [5:0] FunctSrlv = 6'b000110;
  localparam logic [5:0] FunctSrav = 6'b000111;

  // Encoding is architectural: it is exported on the debug state port.
  typedef enum logic [2:0] {
    StInit = 3'd0,
    StIf   = 3'd1,
    StId   = 3'd2,
    StEx   = 3'd3,
    StMem  = 3'd4,
    StWb   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PcSrcSeq    = 2'd0,
    PcSrcBranch = 2'd1,
    PcSrcJump   = 2'd2,
    PcSrcReg    = 2'd3
  } pc_src_e;

  typedef struct packed {
    logic r_format;
    logic i_format;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic jmp;
    logic jal;
    logic jr;
    logic sftmd;
  } dec_t;

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/multicycle_control32_if.sv
// Controller <-> datapath bundle. master = controller (drives strobes, reads IR/ALU
// status and io_ready); slave = datapath side.
//   Opcode/Function_opcode : IR fields        Alu_resultHigh/Zero : ALU status
//   io_ready               : MMIO completion  remaining signals   : control strobes
interface multicycle_control32_if #(
  parameter int unsigned ADDR_HIGH_W = 22
);
  logic [5:0]             Opcode;
  logic [5:0]             Function_opcode;
  logic [ADDR_HIGH_W-1:0] Alu_resultHigh;
  logic                   Zero;
  logic                   io_ready;

  logic                   IRWrite;
  logic                   PCWrite;
  logic [1:0]             PCSrc;
  logic                   RegWrite;
  logic                   RegDST;
  logic                   MemorIOtoReg;
  logic                   Jal;
  logic                   MemRead;
  logic                   MemWrite;
  logic                   IORead;
  logic                   IOWrite;
  logic                   ALUSrc;
  logic                   Sftmd;
  logic [1:0]             ALUOp;
  logic [2:0]             state;
  logic                   io_timeout;

  modport master (
    input  Opcode, Function_opcode, Alu_resultHigh, Zero, io_ready,
    output IRWrite, PCWrite, PCSrc, RegWrite, RegDST, MemorIOtoReg, Jal,
    output MemRead, MemWrite, IORead, IOWrite, ALUSrc, Sftmd, ALUOp, state, io_timeout
  );

  modport slave (
    output Opcode, Function_opcode, Alu_resultHigh, Zero, io_ready,
    input  IRWrite, PCWrite, PCSrc, RegWrite, RegDST, MemorIOtoReg, Jal,
    input  MemRead, MemWrite, IORead, IOWrite, ALUSrc, Sftmd, ALUOp, state, io_timeout
  );
endinterface

// File: rtl/multicycle_control32_decode.sv
// Purely combinational instruction-class decode, shared with the single-cycle core.
//   opcode : IR[31:26]   funct : IR[5:0]   dec : one flag per instruction class
module multicycle_control32_decode
  import multicycle_control32_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);

  logic r_format;
  assign r_format = (opcode == OpRType);

  always_comb begin
    dec          = '0;
    dec.r_format = r_format;
    dec.i_format = (opcode[5:3] == OpIPrefix);
    dec.lw       = (opcode == OpLw);
    dec.sw       = (opcode == OpSw);
    dec.beq      = (opcode == OpBeq);
    dec.bne      = (opcode == OpBne);
    dec.jmp      = (opcode == OpJ);
    dec.jal      = (opcode == OpJal);
    dec.jr       = r_format && (funct == FunctJr);
    dec.sftmd    = r_format && ((funct == FunctSll)  || (funct == FunctSrl)  ||
                                (funct == FunctSra)  || (funct == FunctSllv) ||
                                (funct == FunctSrlv) || (funct == FunctSrav));
  end

endmodule

// File: rtl/multicycle_control32.sv
// Multi-cycle MIPS control unit: IF -> ID -> EX -> (MEM) -> (WB) sequencing with
// per-state datapath strobes, MEM_LAT-cycle RAM accesses, io_ready-terminated MMIO
// accesses with a watchdog, and a sticky io_timeout flag.
//   clock : rising-edge clock      reset : asynchronous, active low
//   bus   : controller side of multicycle_control32_if (IR/ALU in, strobes out)
module multicycle_control32
  import multicycle_control32_pkg::*;
#(
  parameter int unsigned ADDR_HIGH_W             = 22,
  parameter logic [ADDR_HIGH_W-1:0] IO_BASE_HIGH = 22'h3FFFFF,
  parameter int unsigned MEM_LAT                 = 2,
  parameter bit          IO_HANDSHAKE            = 1'b1,
  parameter int unsigned IO_TIMEOUT              = 16
) (
  input logic                    clock,
  input logic                    reset,
  multicycle_control32_if.master bus
);

  localparam int unsigned CntW = $clog2(max_u(MEM_LAT, IO_TIMEOUT)) + 1;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            is_io_q;
  logic            io_timeout_q;

  dec_t dec;

  multicycle_control32_decode u_decode (
    .opcode (bus.Opcode),
    .funct  (bus.Function_opcode),
    .dec    (dec)
  );

  logic goes_mem, goes_wb, branch_taken;
  logic io_wait, ram_done, io_expired, mem_done;

  assign goes_mem     = dec.lw | dec.sw;
  assign goes_wb      = (dec.r_format & ~dec.jr) | dec.i_format | dec.jal;
  assign branch_taken = (dec.beq & bus.Zero) | (dec.bne & ~bus.Zero);

  // With the handshake disabled an IO access is timed exactly like RAM.
  assign io_wait    = is_io_q & IO_HANDSHAKE;
  assign ram_done   = (cnt_q == CntW'(MEM_LAT - 1));
  assign io_expired = (cnt_q == CntW'(IO_TIMEOUT - 1));
  assign mem_done   = io_wait ? (bus.io_ready | io_expired) : ram_done;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StInit;
      cnt_q        <= '0;
      is_io_q      <= 1'b0;
      io_timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: state_q <= StIf;
        StIf:   state_q <= StId;
        StId:   state_q <= StEx;
        StEx: begin
          if (goes_mem) begin
            // Address decision is frozen here; later ALU changes are ignored.
            is_io_q <= (bus.Alu_resultHigh == IO_BASE_HIGH);
            cnt_q   <= '0;
            state_q <= StMem;
          end else if (goes_wb) begin
            state_q <= StWb;
          end else begin
            state_q <= StIf;
          end
        end
        StMem: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem_done) begin
            // Completion without io_ready on an IO access can only be the watchdog.
            if (io_wait && !bus.io_ready) io_timeout_q <= 1'b1;
            state_q <= dec.lw ? StWb : StIf;
          end
        end
        StWb:    state_q <= StIf;
        default: state_q <= StInit;
      endcase
    end
  end

  logic    ir_write, pc_write, reg_write, reg_dst, mem_to_reg, jal;
  logic    mem_read, mem_write, io_read, io_write, alu_src, sftmd;
  logic [1:0] alu_op;
  pc_src_e pc_src;

  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PcSrcSeq;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    jal        = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    io_read    = 1'b0;
    io_write   = 1'b0;
    alu_src    = 1'b0;
    sftmd      = 1'b0;
    alu_op     = 2'b00;
    unique case (state_q)
      StIf: ir_write = 1'b1;
      StEx: begin
        alu_src = dec.i_format | dec.lw | dec.sw;
        alu_op  = {dec.r_format | dec.i_format, dec.beq | dec.bne};
        sftmd   = dec.sftmd;
        if (dec.beq || dec.bne) begin
          pc_write = 1'b1;
          pc_src   = branch_taken ? PcSrcBranch : PcSrcSeq;
        end else if (dec.jmp) begin
          pc_write = 1'b1;
          pc_src   = PcSrcJump;
        end else if (dec.jr) begin
          pc_write = 1'b1;
          pc_src   = PcSrcReg;
        end else if (!goes_mem && !goes_wb) begin
          // Undefined opcode retires as a NOP.
          pc_write = 1'b1;
        end
      end
      StMem: begin
        mem_read  = dec.lw & ~is_io_q;
        mem_write = dec.sw & ~is_io_q;
        io_read   = dec.lw & is_io_q;
        io_write  = dec.sw & is_io_q;
        pc_write  = mem_done & dec.sw;
      end
      StWb: begin
        reg_write  = 1'b1;
        reg_dst    = dec.r_format;
        mem_to_reg = dec.lw;
        jal        = dec.jal;
        pc_write   = 1'b1;
        pc_src     = dec.jal ? PcSrcJump : PcSrcSeq;
      end
      default: ;
    endcase
  end

  assign bus.IRWrite      = ir_write;
  assign bus.PCWrite      = pc_write;
  assign bus.PCSrc        = pc_src;
  assign bus.RegWrite     = reg_write;
  assign bus.RegDST       = reg_dst;
  assign bus.MemorIOtoReg = mem_to_reg;
  assign bus.Jal          = jal;
  assign bus.MemRead      = mem_read;
  assign bus.MemWrite     = mem_write;
  assign bus.IORead       = io_read;
  assign bus.IOWrite      = io_write;
  assign bus.ALUSrc       = alu_src;
  assign bus.Sftmd        = sftmd;
  assign bus.ALUOp        = alu_op;
  assign bus.state        = state_q;
  assign bus.io_timeout   = io_timeout_q;

endmodule

// File: doc/multicycle_control32.md
Name: multicycle_control32

Overview:
- Multi-cycle successor to the single-cycle MIPS decoder.
- Sequences each instruction through fetch, decode, execute, memory and write-back states.
- Emits one-cycle-qualified datapath strobes.
- Adds parametrised memory latency, an io_ready handshake with watchdog timeout, and a latched MMIO address decision.
- Sits between the instruction register / ALU and the PC, register file, RAM and MMIO bridge.

Parameters:
ADDR_HIGH_W, 22, width of Alu_resultHigh (ALU result bits [31:32-ADDR_HIGH_W]).
IO_BASE_HIGH, 22'h3FFFFF, Alu_resultHigh value selecting MMIO instead of RAM.
MEM_LAT, 2, cycles spent in S_MEM for RAM accesses (>=1).
IO_HANDSHAKE, 1, 1: IO access waits for io_ready; 0: IO behaves like RAM with MEM_LAT.
IO_TIMEOUT, 16, maximum S_MEM cycles for IO before forced completion (>=2).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- Opcode  in  6  IR[31:26], stable from S_ID onward.
- Function_opcode  in  6  IR[5:0].
- Alu_resultHigh  in  ADDR_HIGH_W  upper ALU result bits, valid in S_EX.
- Zero  in  1  ALU zero flag, valid in S_EX.
- io_ready  in  1  MMIO bridge completion.
- IRWrite  out  1  load IR.
- PCWrite  out  1  update PC (exactly one cycle per instruction).
- PCSrc  out  2  0 PC+4, 1 branch target, 2 jump target, 3 register (jr).
- RegWrite, RegDST, MemorIOtoReg, Jal  out  1 each  write-back controls.
- MemRead, MemWrite, IORead, IOWrite  out  1 each  access strobes.
- ALUSrc, Sftmd  out  1 each  ALU operand controls.
- ALUOp  out  2  {R_format|I_format, beq|bne}.
- state  out  3  current FSM state, for debug.
- io_timeout  out  1  sticky: an IO access hit the watchdog.

Behaviour:
States (encoding 0–5):
- S_INIT: all strobes 0. Next: S_IF.
- S_IF: IRWrite=1. Next: S_ID.
- S_ID: decode only. Next: S_EX.
- S_EX: ALUSrc, ALUOp and Sftmd driven from decode. Next state by instruction class:
  - beq/bne: PCWrite=1; PCSrc=1 if (beq&Zero)|(bne&!Zero), else 0. Next: S_IF.
  - j: PCWrite=1, PCSrc=2. Next: S_IF.
  - jr (opcode 0, funct 001000): PCWrite=1, PCSrc=3. Next: S_IF.
  - lw/sw: latch is_io = (Alu_resultHigh == IO_BASE_HIGH); clear wait counter. Next: S_MEM.
  - R-format (non-jr), I-format (opcode[5:3]=001), jal: Next: S_WB.
  - Undefined opcode: PCWrite=1, PCSrc=0 (NOP). Next: S_IF.
- S_MEM:
  - Strobes held for the whole dwell: MemRead=lw&!is_io, MemWrite=sw&!is_io, IORead=lw&is_io, IOWrite=sw&is_io.
  - Counter increments each cycle; width $clog2(max(MEM_LAT, IO_TIMEOUT))+1.
  - RAM: done when counter == MEM_LAT-1.
  - IO with IO_HANDSHAKE=1: done when io_ready=1, or when counter == IO_TIMEOUT-1. The timeout case sets io_timeout.
  - io_ready sampled in a non-IO state is ignored.
  - On done: sw asserts PCWrite (PCSrc=0), next S_IF. lw goes to S_WB.
- S_WB:
  - RegWrite=1; RegDST=R_format; MemorIOtoReg=lw; Jal=jal.
  - PCWrite=1; PCSrc=2 for jal, else 0.
  - Next: S_IF.
- Is_io latching: is_io is latched once in S_EX; Alu_resultHigh changes during S_MEM have no effect.
- Strobe gating: strobes outside their listed states are 0. ALU controls may be driven in any state but are only required in S_EX.
- Reset (async, any time including mid-S_MEM):
  - state=S_INIT, counter=0, is_io=0, io_timeout=0.
  - All outputs 0, PCSrc=0, state=0.
  - Strobes drop in the same cycle reset asserts.
- io_timeout clears only on reset.
- Latency per instruction (cycles, excluding S_INIT):
  - branch / jump / NOP: 3
  - ALU / jal: 4
  - sw: 3+MEM_LAT
  - lw: 4+MEM_LAT
  - IO: variable.

Decomposition:
- Shared package (control_pkg): opcode and funct constants, state encoding, PCSrc encodings.
- Sub-module control_decode: combinational class decode (R/I/lw/sw/branch/jump/shift/jr), reusable by the single-cycle core.
- FSM, counter and is_io register stay in multicycle_control32.

Test Plan:
- add (op 000000, funct 100000) -> IRWrite in cycle 1, RegWrite=1 and PCWrite=1 (PCSrc=0) in cycle 4, S_IF in cycle 5.
- beq with Zero=1 -> PCWrite=1, PCSrc=1 in S_EX, no RegWrite. With Zero=0 -> PCSrc=0. Repeat for bne (reversed).
- lw, Alu_resultHigh=22'h000010, MEM_LAT=2 -> MemRead high exactly 2 cycles, then RegWrite=1 with MemorIOtoReg=1.
- sw, Alu_resultHigh=22'h3FFFFF, io_ready raised on the 3rd S_MEM cycle -> IOWrite high 3 cycles, then PCWrite; io_timeout stays 0. Changing Alu_resultHigh mid-access has no effect.
- lw to IO, io_ready held 0 -> IORead high 16 cycles, io_timeout=1, RegWrite=1 next, flag stays set across further instructions.
- reset=0 pulsed during lw S_MEM -> all strobes 0 immediately; after release: S_INIT then S_IF, io_timeout=0. jal -> S_WB with RegWrite=1, Jal=1, PCSrc=2.
